fetch_ctrl: RTL and testbench

- Sequences the program counter and the instruction-memory fetch handshake.
- Arbitrates redirect requests (exception, eret, branch, jump-imm, jump-reg) by fixed priority. Holds a redirect that arrives mid-fetch until the bus transaction completes.
- Buffers one fetched word across decode stalls.
- Sits between the hazard/branch/CP0 logic and the PC register; drives the PC's enable and take* selects.

---
 rtl/fetch_ctrl_pkg.sv | 24 ++
 rtl/fetch_ctrl_redirect_arb.sv | 26 ++
 rtl/fetch_ctrl.sv | 154 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch controller: FSM states and redirect kinds.
// Redirect kinds are numbered so that a larger value means higher priority.
package fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      StBoot  = 2'd0,
      StFetch = 2'd1,
      StHold  = 2'd2
   } stateT;

   typedef enum logic [2:0] {
      KindNone = 3'd0,
      KindJReg = 3'd1,
      KindJImm = 3'd2,
      KindBr   = 3'd3,
      KindEret = 3'd4,
      KindExc  = 3'd5
   } kindT;

   function automatic kindT maxKind(input kindT a, input kindT b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/fetch_ctrl_redirect_arb.sv
// Fixed-priority merge of the five redirect requests with the held pending kind.
module fetch_ctrl_redirect_arb
   import fetch_ctrl_pkg::*;
(
   input  logic excReq,
   input  logic eretReq,
   input  logic brReq,
   input  logic jImmReq,
   input  logic jRegReq,
   input  kindT pending,
   output kindT merged
);

   kindT newKind;

   always_comb begin
      newKind = KindNone;
      if (excReq)       newKind = KindExc;
      else if (eretReq) newKind = KindEret;
      else if (brReq)   newKind = KindBr;
      else if (jImmReq) newKind = KindJImm;
      else if (jRegReq) newKind = KindJReg;
      merged = maxKind(pending, newKind);
   end

endmodule

// File: rtl/fetch_ctrl.sv
// PC sequencing and instruction-fetch handshake with redirect arbitration and a
// one-word stall buffer. Define FETCH_TIMEOUT_EN to add the ack watchdog.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        excReq,
   input  logic        eretReq,
   input  logic        brReq,
   input  logic        jImmReq,
   input  logic        jRegReq,
   input  logic        stall,
   input  logic        imemAck,
   input  logic [31:0] imemRdata,
   output logic        imemReq,
   output logic        pcEn,
   output logic        takeException,
   output logic        takeEret,
   output logic        takeBranch,
   output logic        takeJumpImm,
   output logic        takeJumpReg,
   output logic        flushIf,
   output logic [31:0] instr,
   output logic        instrValid,
   output logic        fetchTimeout
);

   stateT       stateQ, stateD;
   kindT        pendingQ, pendingD;
   kindT        merged, issue;
   logic [31:0] bufQ, bufD;
   logic        timeoutHit;

   fetch_ctrl_redirect_arb uArb (
      .excReq  (excReq),
      .eretReq (eretReq),
      .brReq   (brReq),
      .jImmReq (jImmReq),
      .jRegReq (jRegReq),
      .pending (pendingQ),
      .merged  (merged)
   );

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned CntW =
      ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CntW-1:0] cntQ, cntD;

   // Fires on the TIMEOUT_CYCLES-th consecutive FETCH cycle without ack.
   assign timeoutHit = (stateQ == StFetch) && !imemAck &&
                       (cntQ == CntW'(TIMEOUT_CYCLES - 1));
   assign cntD = ((stateQ != StFetch) || imemAck || timeoutHit) ? '0 : cntQ + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) cntQ <= '0;
      else     cntQ <= cntD;
   end
`else
   logic unusedTimeout;
   assign unusedTimeout = (TIMEOUT_CYCLES == 0);
   assign timeoutHit    = 1'b0;
`endif

   assign fetchTimeout = timeoutHit;

   always_comb begin
      stateD     = stateQ;
      pendingD   = pendingQ;
      bufD       = bufQ;
      imemReq    = 1'b0;
      pcEn       = 1'b0;
      issue      = KindNone;
      flushIf    = 1'b0;
      instr      = '0;
      instrValid = 1'b0;
      unique case (stateQ)
         StBoot: begin
            pendingD = merged;
            stateD   = StFetch;
         end
         StFetch: begin
            imemReq = 1'b1;
            if (timeoutHit) begin
               issue    = KindExc;
               pcEn     = 1'b1;
               flushIf  = 1'b1;
               pendingD = KindNone;
            end else if (!imemAck) begin
               // Bus transaction still open: park the redirect until it completes.
               pendingD = merged;
            end else if (merged != KindNone) begin
               issue    = merged;
               pcEn     = 1'b1;
               flushIf  = 1'b1;
               pendingD = KindNone;
            end else if (!stall) begin
               instr      = imemRdata;
               instrValid = 1'b1;
               pcEn       = 1'b1;
            end else begin
               bufD   = imemRdata;
               stateD = StHold;
            end
         end
         StHold: begin
            instr = bufQ;
            if (merged != KindNone) begin
               issue    = merged;
               pcEn     = 1'b1;
               flushIf  = 1'b1;
               pendingD = KindNone;
               stateD   = StFetch;
            end else if (!stall) begin
               instrValid = 1'b1;
               pcEn       = 1'b1;
               stateD     = StFetch;
            end
         end
         default: stateD = StBoot;
      endcase
   end

   always_comb begin
      takeException = 1'b0;
      takeEret      = 1'b0;
      takeBranch    = 1'b0;
      takeJumpImm   = 1'b0;
      takeJumpReg   = 1'b0;
      unique case (issue)
         KindExc:  takeException = 1'b1;
         KindEret: takeEret      = 1'b1;
         KindBr:   takeBranch    = 1'b1;
         KindJImm: takeJumpImm   = 1'b1;
         KindJReg: takeJumpReg   = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ   <= StBoot;
         pendingQ <= KindNone;
         bufQ     <= '0;
      end else begin
         stateQ   <= stateD;
         pendingQ <= pendingD;
         bufQ     <= bufD;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: each driven cycle queues its expected outputs,
// which are popped and compared on the following falling edge.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        excReq, eretReq, brReq, jImmReq, jRegReq;
   logic        stall, imemAck;
   logic [31:0] imemRdata;
   logic        imemReq, pcEn, flushIf, instrValid, fetchTimeout;
   logic        takeException, takeEret, takeBranch, takeJumpImm, takeJumpReg;
   logic [31:0] instr;

   always #5 clk = ~clk;

   fetch_ctrl #(
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .excReq        (excReq),
      .eretReq       (eretReq),
      .brReq         (brReq),
      .jImmReq       (jImmReq),
      .jRegReq       (jRegReq),
      .stall         (stall),
      .imemAck       (imemAck),
      .imemRdata     (imemRdata),
      .imemReq       (imemReq),
      .pcEn          (pcEn),
      .takeException (takeException),
      .takeEret      (takeEret),
      .takeBranch    (takeBranch),
      .takeJumpImm   (takeJumpImm),
      .takeJumpReg   (takeJumpReg),
      .flushIf       (flushIf),
      .instr         (instr),
      .instrValid    (instrValid),
      .fetchTimeout  (fetchTimeout)
   );

   // Flags: {imemReq, pcEn, take[exc,eret,br,jimm,jreg], flushIf, instrValid, fetchTimeout}
   localparam logic [4:0] T_NONE = 5'b00000;
   localparam logic [4:0] T_EXC  = 5'b10000;
   localparam logic [4:0] T_ERET = 5'b01000;
   localparam logic [4:0] T_BR   = 5'b00100;
   localparam logic [4:0] T_JIMM = 5'b00010;
   localparam logic [4:0] T_JREG = 5'b00001;

   localparam logic [9:0] F_ZERO  = 10'b0;
   localparam logic [9:0] F_WAIT  = {1'b1, 1'b0, T_NONE, 1'b0, 1'b0, 1'b0};
   localparam logic [9:0] F_DELIV = {1'b1, 1'b1, T_NONE, 1'b0, 1'b1, 1'b0};
   localparam logic [9:0] F_HOLD  = {1'b0, 1'b0, T_NONE, 1'b0, 1'b0, 1'b0};
   localparam logic [9:0] F_HDLV  = {1'b0, 1'b1, T_NONE, 1'b0, 1'b1, 1'b0};

   function automatic logic [9:0] fRedir(input logic req, input logic [4:0] take);
      return {req, 1'b1, take, 1'b1, 1'b0, 1'b0};
   endfunction

   typedef struct packed {
      logic [9:0]  flags;
      logic        chkI;
      logic [31:0] instr;
   } expT;

   expT expQ[$];
   int  checks   = 0;
   int  failures = 0;
   int  stepNo   = 0;

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         expT e;
         e = expQ.pop_front();
         checkEq($sformatf("step%0d flags", stepNo),
                 {22'b0, imemReq, pcEn, takeException, takeEret, takeBranch,
                  takeJumpImm, takeJumpReg, flushIf, instrValid, fetchTimeout},
                 {22'b0, e.flags});
         if (e.chkI) checkEq($sformatf("step%0d instr", stepNo), instr, e.instr);
         stepNo++;
      end
   end

   // req order: {exc, eret, br, jImm, jReg}
   task automatic cyc(input logic [4:0] req, input logic st, input logic ack,
                      input logic [31:0] d, input logic [9:0] ef,
                      input logic ci, input logic [31:0] ei);
      expT e;
      @(posedge clk);
      #1;
      rst = 1'b0;
      {excReq, eretReq, brReq, jImmReq, jRegReq} = req;
      stall     = st;
      imemAck   = ack;
      imemRdata = d;
      e.flags = ef;
      e.chkI  = ci;
      e.instr = ei;
      expQ.push_back(e);
   endtask

   task automatic rstCyc();
      @(posedge clk);
      #1;
      rst = 1'b1;
      {excReq, eretReq, brReq, jImmReq, jRegReq} = 5'b0;
      stall     = 1'b0;
      imemAck   = 1'b0;
      imemRdata = '0;
   endtask

   initial begin
      rst = 1'b1;
      {excReq, eretReq, brReq, jImmReq, jRegReq} = 5'b0;
      stall     = 1'b0;
      imemAck   = 1'b0;
      imemRdata = '0;
      rstCyc();
      rstCyc();

      // Boot cycle ignores ack, then back-to-back delivery.
      cyc(T_NONE, 0, 1, 32'h0, F_ZERO, 1, 32'h0);
      cyc(T_NONE, 0, 1, 32'h1, F_DELIV, 1, 32'h1);
      cyc(T_NONE, 0, 1, 32'h2, F_DELIV, 1, 32'h2);
      cyc(T_NONE, 0, 1, 32'h3, F_DELIV, 1, 32'h3);

      // Branch held until ack three cycles later.
      cyc(T_BR,   0, 0, 32'h0,  F_WAIT, 1, 32'h0);
      cyc(T_NONE, 0, 0, 32'h0,  F_WAIT, 0, 32'h0);
      cyc(T_NONE, 0, 0, 32'h0,  F_WAIT, 0, 32'h0);
      cyc(T_NONE, 0, 1, 32'h11, fRedir(1, T_BR), 0, 32'h0);
      cyc(T_NONE, 0, 1, 32'h5,  F_DELIV, 1, 32'h5);

      // Pending upgraded by a higher request, never downgraded.
      cyc(T_JREG, 0, 0, 32'h0,  F_WAIT, 0, 32'h0);
      cyc(T_EXC,  0, 0, 32'h0,  F_WAIT, 0, 32'h0);
      cyc(T_NONE, 0, 1, 32'h12, fRedir(1, T_EXC), 0, 32'h0);
      cyc(T_NONE, 0, 1, 32'h6,  F_DELIV, 1, 32'h6);
      cyc(T_EXC,  0, 0, 32'h0,  F_WAIT, 0, 32'h0);
      cyc(T_BR,   0, 0, 32'h0,  F_WAIT, 0, 32'h0);
      cyc(T_NONE, 0, 1, 32'h13, fRedir(1, T_EXC), 0, 32'h0);
      cyc(T_NONE, 0, 1, 32'h7,  F_DELIV, 1, 32'h7);

      // Simultaneous requests on an ack cycle resolve to the highest only.
      cyc(T_BR | T_JIMM, 0, 1, 32'h14, fRedir(1, T_BR), 0, 32'h0);
      cyc(T_JIMM | T_JREG, 1, 1, 32'h15, fRedir(1, T_JIMM), 0, 32'h0);
      cyc(T_NONE, 0, 1, 32'h8,  F_DELIV, 1, 32'h8);

      // Stall buffering across four stalled cycles.
      cyc(T_NONE, 1, 1, 32'hDEADBEEF, F_WAIT, 0, 32'h0);
      cyc(T_NONE, 1, 0, 32'h0, F_HOLD, 1, 32'hDEADBEEF);
      cyc(T_NONE, 1, 0, 32'h0, F_HOLD, 1, 32'hDEADBEEF);
      cyc(T_NONE, 1, 0, 32'h0, F_HOLD, 1, 32'hDEADBEEF);
      cyc(T_NONE, 0, 1, 32'h99, F_HDLV, 1, 32'hDEADBEEF);
      cyc(T_NONE, 0, 1, 32'h9,  F_DELIV, 1, 32'h9);

      // Eret in HOLD overrides stall and discards the buffered word.
      cyc(T_NONE, 1, 1, 32'hCAFE0001, F_WAIT, 0, 32'h0);
      cyc(T_NONE, 1, 0, 32'h0, F_HOLD, 1, 32'hCAFE0001);
      cyc(T_ERET, 1, 0, 32'h0, fRedir(0, T_ERET), 0, 32'h0);
      cyc(T_NONE, 0, 1, 32'h77, F_DELIV, 1, 32'h77);

      // Reset mid-transaction clears the parked redirect.
      cyc(T_BR,   0, 0, 32'h0,  F_WAIT, 0, 32'h0);
      rstCyc();
      cyc(T_NONE, 0, 1, 32'hAA, F_ZERO, 1, 32'h0);
      cyc(T_NONE, 0, 1, 32'hA,  F_DELIV, 1, 32'hA);

`ifdef FETCH_TIMEOUT_EN
      cyc(T_NONE, 0, 0, 32'h0, F_WAIT, 0, 32'h0);
      cyc(T_NONE, 0, 0, 32'h0, F_WAIT, 0, 32'h0);
      cyc(T_NONE, 0, 0, 32'h0, F_WAIT, 0, 32'h0);
      cyc(T_NONE, 0, 0, 32'h0, {1'b1, 1'b1, T_EXC, 1'b1, 1'b0, 1'b1}, 0, 32'h0);
      cyc(T_NONE, 0, 1, 32'hB, F_DELIV, 1, 32'hB);
`else
      for (int i = 0; i < 6; i++) cyc(T_NONE, 0, 0, 32'h0, F_WAIT, 0, 32'h0);
      cyc(T_NONE, 0, 1, 32'hB, F_DELIV, 1, 32'hB);
`endif

      @(posedge clk);
      #1;
      imemAck = 1'b0;
      @(negedge clk);
      #1;
      checkEq("queue drained", expQ.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
